load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the byte-addressed, big-endian data memory. Drives the memory's word write port, implements byte/halfword stores as a two-cycle read-modify-write with a pipeline stall, extracts and sign/zero-extends load data, and registers the result into the MEM/WB interface. Adds no latency to word loads or word stores.

## Interface
- `WIDTH`, 32, data/address width. Only 32 is supported.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a memory op is present in EX/MEM this cycle.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend load data; ignored for stores.
- `req_addr` in WIDTH: byte address.
- `req_wdata` in WIDTH: store data, right-justified.
- `req_rd` in 5: destination register for loads.
- `stall` out 1: combinational; upstream holds all `req_*` inputs stable while high.
- `mem_w` out 1: write enable to data memory.
- `mem_addr` out WIDTH: address to data memory.
- `mem_wdata` out WIDTH: write data to data memory.
- `mem_rdata` in WIDTH: combinational read data; bytes `addr..addr+3`, MSB first.
- `wb_valid` out 1: registered; load result is valid.
- `wb_rd` out 5: registered destination register.
- `wb_data` out WIDTH: registered load result.
- `misalign` out 1: registered one-cycle pulse. Present only with `LSU_MISALIGN_TRAP_EN`.

## Operation
- FSM states are IDLE and RMW_WR. Reset state is IDLE.
- IDLE, load:
  - `mem_addr`=`req_addr`, `mem_w`=0.
  - Byte result: `mem_rdata[31:24]`. Half result: `mem_rdata[31:16]`. Word result: `mem_rdata`.
  - Byte and half results are sign-extended, or zero-extended when `req_unsigned`=1.
  - The result is registered into `wb_*` at the posedge.
- IDLE, word store: `mem_w`=1, `mem_addr`=`req_addr`, `mem_wdata`=`req_wdata` in the same cycle. No stall.
- IDLE, byte/half store:
  - `stall`=1, `mem_w`=0, `mem_addr`=`req_addr`.
  - The merged word is latched at the posedge:
    - byte: {`req_wdata[7:0]`, `mem_rdata[23:0]`}
    - half: {`req_wdata[15:0]`, `mem_rdata[15:0]`}
  - The address is latched at the same posedge, and the FSM goes to RMW_WR.
- RMW_WR:
  - `mem_w`=1, with `mem_addr` and `mem_wdata` taken from the latches.
  - `stall`=0, so the held request retires at this posedge.
  - Request inputs are ignored in this state. Next state is IDLE.
- `wb_valid`=1 only for a completed load with `req_rd`≠0. Otherwise `wb_valid`=0; `wb_rd` and `wb_data` hold their previous values.
- `req_valid`=0 in IDLE: `mem_w`=0, `stall`=0, `wb_valid`←0.
- The address is passed through unchanged. Range checks belong to the memory.

## Timing
- Reset values:
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `misalign`=0.
  - FSM=IDLE, merge and address latches=0.
- While `rst`=1: `mem_w`=0 and `stall`=0, combinationally.
- Latency:
  - Load: result on `wb_*` 1 cycle after the request cycle.
  - Word store: committed at the request-cycle posedge.
  - Sub-word store: 2 cycles, with the write committed at the end of cycle 2 and `stall` high in cycle 1 only.
- Back-to-back ops:
  - A load or store immediately after an RMW sees the RMW result, because the write commits before the next read.
  - Back-to-back sub-word stores to the same word each perform a full RMW.
- Reset asserted in RMW_WR: the write is dropped, the FSM goes to IDLE, and memory is unchanged.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - A misaligned request is suppressed: `mem_w`=0, no stall, no RMW, `wb_valid`←0.
  - `misalign` pulses 1 for the next cycle.
- Not defined:
  - The `misalign` port is absent.
  - Unaligned accesses proceed at `req_addr` as-is, since memory supports any byte address.

## Test plan
- Word store then load:
  - sw 0xDEADBEEF @0x10.
  - Next cycle, lw rd=5 @0x10 → `wb_valid`=1, `wb_rd`=5, `wb_data`=0xDEADBEEF one cycle later. No stall.
- Sign/zero extension:
  - mem @0x20 = 0x80FF1234.
  - lb → 0xFFFFFF80; lbu → 0x00000080; lh → 0xFFFF80FF; lhu @0x22 → 0x00001234.
- Byte RMW:
  - mem @0x10 = 0xDEADBEEF; sb 0x55 @0x10.
  - `stall`=1 for exactly 1 cycle. `mem_w`=1 in cycle 2 with `mem_wdata`=0x55ADBEEF. Then lw → 0x55ADBEEF.
- Reset in RMW_WR: sh @0x30, assert `rst` in cycle 2 → memory @0x30 unchanged, all outputs at reset values.
- Load with rd=0 → `wb_valid`=0.
- `LSU_MISALIGN_TRAP_EN`: lw @0x13 → `misalign`=1 next cycle, `wb_valid`=0. sw @0x11 → no `mem_w`.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word ops pass straight through; byte/half stores use a stalled
// two-cycle read-modify-write. Optional misalignment trap is enabled by LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_store,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             stall,
    output logic             mem_w,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic             misalign
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] merge_q, merge_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             mis_c;
    logic [WIDTH-1:0] load_c;
    logic             word_c;

    assign word_c = req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign mis_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                   (word_c && (req_addr[1:0] != 2'b00));
    assign misalign = misalign_q;
`else
    assign mis_c = 1'b0;
`endif

    // Big-endian extraction: the addressed byte/half sits in the top of the read word.
    always_comb begin
        load_c = mem_rdata;
        case (req_size)
            SZ_BYTE: load_c = {{(WIDTH-8){mem_rdata[31] & ~req_unsigned}}, mem_rdata[31:24]};
            SZ_HALF: load_c = {{(WIDTH-16){mem_rdata[31] & ~req_unsigned}}, mem_rdata[31:16]};
            default: load_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        addr_d     = addr_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        stall      = 1'b0;
        mem_w      = 1'b0;
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = req_valid && (state_q == IDLE) && mis_c;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && !mis_c) begin
                    if (req_store) begin
                        if (word_c) begin
                            mem_w = 1'b1;
                        end else begin
                            // Sub-word store: read this cycle, write the merged word next cycle.
                            stall   = 1'b1;
                            addr_d  = req_addr;
                            state_d = RMW_WR;
                            if (req_size == SZ_BYTE) begin
                                merge_d = {req_wdata[7:0], mem_rdata[23:0]};
                            end else begin
                                merge_d = {req_wdata[15:0], mem_rdata[15:0]};
                            end
                        end
                    end else if (req_rd != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = req_rd;
                        wb_data_d  = load_c;
                    end
                end
            end
            default: begin
                mem_w     = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                state_d   = IDLE;
            end
        endcase

        if (rst) begin
            mem_w = 1'b0;
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            merge_q    <= '0;
            addr_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            merge_q    <= merge_d;
            addr_q     <= addr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model plus a byte-array reference of
// architectural memory; directed plan cases followed by random ops.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        stall;
    logic        mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    load_store_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .stall(stall), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: 256 bytes, big-endian, address wraps at 8 bits.
    logic [7:0] mem [256];
    logic       mem_clr;
    logic [7:0] ma;
    assign ma = mem_addr[7:0];
    assign mem_rdata = {mem[ma], mem[8'(ma + 8'd1)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd3)]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_w) begin
            mem[ma]             <= mem_wdata[31:24];
            mem[8'(ma + 8'd1)]  <= mem_wdata[23:16];
            mem[8'(ma + 8'd2)]  <= mem_wdata[15:8];
            mem[8'(ma + 8'd3)]  <= mem_wdata[7:0];
        end
    end

    // Reference: architectural memory contents and last write-back registers.
    logic [7:0]  ref_mem [256];
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd3)]};
    endfunction

    task automatic do_op(input bit st, input logic [1:0] sz, input bit uns,
                         input logic [7:0] a, input logic [31:0] wd, input logic [4:0] rd);
        logic [31:0] exp_w;
        logic [31:0] exp_ld;
        bit word;
        bit mis;
        bit sub_st;
        word   = sz[1];
        mis    = MIS_EN && (((sz == 2'b01) && a[0]) || (word && (a[1:0] != 2'b00)));
        sub_st = st && !word && !mis;
        exp_w  = 32'h0;
        exp_ld = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = {24'h0, a}; req_wdata = wd; req_rd = rd;
        #1;
        if (mis) begin
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_memw", 32'(mem_w), 32'd0);
        end else if (st && word) begin
            chk("sw_memw", 32'(mem_w), 32'd1);
            chk("sw_stall", 32'(stall), 32'd0);
            chk("sw_addr", mem_addr, {24'h0, a});
            chk("sw_wdata", mem_wdata, wd);
            for (int i = 0; i < 4; i++) ref_mem[8'(a + 8'(i))] = wd[8*(3-i) +: 8];
        end else if (st) begin
            chk("rmw1_stall", 32'(stall), 32'd1);
            chk("rmw1_memw", 32'(mem_w), 32'd0);
            chk("rmw1_addr", mem_addr, {24'h0, a});
            if (sz == 2'b00) begin
                ref_mem[a] = wd[7:0];
            end else begin
                ref_mem[a] = wd[15:8];
                ref_mem[8'(a + 8'd1)] = wd[7:0];
            end
            exp_w = ref_word(a);
        end else begin
            chk("ld_memw", 32'(mem_w), 32'd0);
            chk("ld_stall", 32'(stall), 32'd0);
            chk("ld_addr", mem_addr, {24'h0, a});
            if (word) exp_ld = ref_word(a);
            else if (sz == 2'b00) exp_ld = uns ? {24'h0, ref_mem[a]} : 32'(signed'(ref_mem[a]));
            else exp_ld = uns ? {16'h0, ref_mem[a], ref_mem[8'(a + 8'd1)]}
                              : 32'(signed'({ref_mem[a], ref_mem[8'(a + 8'd1)]}));
        end
        @(posedge clk); #1;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalign", 32'(misalign), 32'(mis));
`endif
        if (sub_st) begin
            chk("rmw2_memw", 32'(mem_w), 32'd1);
            chk("rmw2_stall", 32'(stall), 32'd0);
            chk("rmw2_addr", mem_addr, {24'h0, a});
            chk("rmw2_wdata", mem_wdata, exp_w);
            @(posedge clk); #1;
        end
        if (!st && !mis && rd != 5'd0) begin
            last_rd = rd;
            last_data = exp_ld;
            chk("wb_valid", 32'(wb_valid), 32'd1);
        end else begin
            chk("wb_valid0", 32'(wb_valid), 32'd0);
        end
        chk("wb_rd", 32'(wb_rd), 32'(last_rd));
        chk("wb_data", wb_data, last_data);
        req_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        last_rd = 5'd0; last_data = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF; req_rd = 5'd1;
        #1;
        chk("rst_memw", 32'(mem_w), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(misalign), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0; req_valid = 1'b0;
        #1;
        chk("idle_memw", 32'(mem_w), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);

        // Word store then load.
        do_op(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 5'd0);
        do_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 5'd5);
        chk("lw_lit", wb_data, 32'hDEADBEEF);

        // Sign/zero extension.
        do_op(1'b1, 2'b10, 1'b0, 8'h20, 32'h80FF1234, 5'd0);
        do_op(1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 5'd6);
        chk("lb_lit", wb_data, 32'hFFFFFF80);
        do_op(1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 5'd7);
        chk("lbu_lit", wb_data, 32'h00000080);
        do_op(1'b0, 2'b01, 1'b0, 8'h20, 32'h0, 5'd8);
        chk("lh_lit", wb_data, 32'hFFFF80FF);
        do_op(1'b0, 2'b01, 1'b1, 8'h22, 32'h0, 5'd9);
        chk("lhu_lit", wb_data, 32'h00001234);

        // Byte RMW, then back-to-back sub-word stores and an immediate load.
        do_op(1'b1, 2'b00, 1'b0, 8'h10, 32'h00000055, 5'd0);
        do_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 5'd10);
        chk("sb_lw_lit", wb_data, 32'h55ADBEEF);
        do_op(1'b1, 2'b00, 1'b0, 8'h11, 32'h00000066, 5'd0);
        do_op(1'b1, 2'b01, 1'b0, 8'h12, 32'h00007788, 5'd0);
        do_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 5'd11);
        chk("b2b_lit", wb_data, 32'h55667788);

        // Load to r0 leaves wb_rd/wb_data untouched.
        do_op(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 5'd0);

        // Reset during RMW_WR drops the write.
        do_op(1'b1, 2'b10, 1'b0, 8'h30, 32'h11223344, 5'd0);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h0000A5A5; req_rd = 5'd0;
        #1;
        chk("rstrmw_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstrmw_memw", 32'(mem_w), 32'd0);
        chk("rstrmw_stall0", 32'(stall), 32'd0);
        @(posedge clk); #1;
        last_rd = 5'd0; last_data = 32'h0;
        chk("rstrmw_wb_valid", 32'(wb_valid), 32'd0);
        chk("rstrmw_wb_rd", 32'(wb_rd), 32'd0);
        chk("rstrmw_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("postrst_memw", 32'(mem_w), 32'd0);
        do_op(1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 5'd12);
        chk("rstrmw_lit", wb_data, 32'h11223344);

        // Unaligned accesses (trapped only when the trap is built in).
        do_op(1'b0, 2'b10, 1'b0, 8'h13, 32'h0, 5'd3);
        do_op(1'b1, 2'b10, 1'b0, 8'h11, 32'hCAFEF00D, 5'd0);
        do_op(1'b1, 2'b01, 1'b0, 8'h21, 32'h0000BEAD, 5'd0);
        do_op(1'b0, 2'b01, 1'b1, 8'h21, 32'h0, 5'd4);

        // Random ops over a small window to force address reuse.
        for (int n = 0; n < 400; n++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 63)), $urandom(), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); #1;
                chk("gap_memw", 32'(mem_w), 32'd0);
                chk("gap_stall", 32'(stall), 32'd0);
                @(posedge clk); #1;
                chk("gap_wb_valid", 32'(wb_valid), 32'd0);
            end
        end

        // Final memory image against the reference.
        @(negedge clk);
        for (int i = 0; i < 256; i += 4) begin
            chk("mem_image", {mem[i], mem[i+1], mem[i+2], mem[i+3]},
                {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
